// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - key/collision inputs and playfield control outputs of the round sequencer
interface game_sequencer_if #(
    parameter int SCORE_W = 8
);
    logic               start;
    logic               lose;
    logic               pass;
    logic               tick;
    logic               spawn;
    logic [7:0]         pipe_col;
    logic [SCORE_W-1:0] score;
    logic [1:0]         state;
    logic               freeze;

    // Drives the key and collision levels, observes the sequencer outputs
    modport master (
        output start, lose, pass,
        input  tick, spawn, pipe_col, score, state, freeze
    );

    // The sequencer itself
    modport slave (
        input  start, lose, pass,
        output tick, spawn, pipe_col, score, state, freeze
    );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - round FSM, game tick, pipe spawning and scoring for the 8x8 flappy-bird playfield
module game_sequencer #(
    parameter int TICK_DIV     = 8,
    parameter int PIPE_SPACING = 4,
    parameter int GAP_H        = 3,
    parameter int SCORE_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    game_sequencer_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;

    localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]      SPACE_LAST = SW'(PIPE_SPACING - 1);
    localparam logic [7:0]         GAP_ONES   = 8'((1 << GAP_H) - 1);
    localparam logic [3:0]         BASE_MAX   = 4'(8 - GAP_H);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    logic [1:0]         r_state;
    logic [TW-1:0]      r_tick_cnt;
    logic [SW-1:0]      r_space_cnt;
    logic [7:0]         r_lfsr;
    logic               r_pass_d;
    logic [SCORE_W-1:0] r_score;

    logic               w_play;
    logic               w_tick;
    logic               w_spawn;
    logic               w_fb;
    logic               w_score_inc;
    logic [3:0]         w_base;
    logic [7:0]         w_gap_mask;

    // All outputs decode from registers only, so lose/pass never reach them combinationally
    assign w_play      = (r_state == ST_PLAY);
    assign w_tick      = w_play && (r_tick_cnt == TICK_LAST);
    assign w_spawn     = w_tick && (r_space_cnt == SPACE_LAST);
    assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_score_inc = w_play && bus.pass && !r_pass_d && !bus.lose;
    assign w_gap_mask  = GAP_ONES << w_base;

    // Gap start row comes from the LFSR, pulled down so the whole gap fits in 8 rows
    always_comb begin
        w_base = {1'b0, r_lfsr[2:0]};
        if (w_base > BASE_MAX) begin
            w_base = BASE_MAX;
        end
    end

    // Round FSM with the tick divider, spawn spacing counter and score kept alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_space_cnt <= '0;
            r_score     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_PLAY;
                        r_tick_cnt  <= '0;
                        r_space_cnt <= '0;
                        r_score     <= '0;
                    end
                end
                ST_PLAY: begin
                    if (bus.lose) begin
                        r_state    <= ST_OVER;
                        r_tick_cnt <= '0;
                    end else begin
                        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
                        if (w_tick) begin
                            r_space_cnt <= (r_space_cnt == SPACE_LAST) ? '0 : r_space_cnt + SW'(1);
                        end
                        if (w_score_inc && (r_score != SCORE_MAX)) begin
                            r_score <= r_score + SCORE_W'(1);
                        end
                    end
                end
                ST_OVER: begin
                    if (bus.start) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

    // Free-running gap generator and pass edge detector run in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr   <= 8'hA5;
            r_pass_d <= 1'b0;
        end else begin
            r_lfsr   <= {r_lfsr[6:0], w_fb};
            r_pass_d <= bus.pass;
        end
    end

    assign bus.tick     = w_tick;
    assign bus.spawn    = w_spawn;
    assign bus.pipe_col = w_spawn ? ~w_gap_mask : 8'h00;
    assign bus.score    = r_score;
    assign bus.state    = r_state;
    assign bus.freeze   = (r_state == ST_OVER);
endmodule
